// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FPU request arbiter: FPU opcodes, FSM states
// and the latched request record.
package fpu_arb_pkg;

    localparam logic [1:0] CMD_FPU_ILL = 2'b00;
    localparam logic [1:0] CMD_FPU_ADD = 2'b01;
    localparam logic [1:0] CMD_FPU_MUL = 2'b10;
    localparam logic [1:0] CMD_FPU_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] din1;
        logic [31:0] din2;
    } req_t;

    function automatic logic cmd_is_legal(input logic [1:0] cmd);
        return cmd != CMD_FPU_ILL;
    endfunction

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: first requester at or after
// last_grant+1 (with wrap-around) wins.
module fpu_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_grant) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU between NREQ requesters: round-robin grant, one operation
// in flight, result returned with requester ID. Optional watchdog: FPU_ARB_TIMEOUT_EN.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned IDW            = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_cmd,
    input  logic [32*NREQ-1:0]   req_din1,
    input  logic [32*NREQ-1:0]   req_din2,
    output logic [1:0]           fpu_cmd,
    output logic [31:0]          fpu_din1,
    output logic [31:0]          fpu_din2,
    output logic                 fpu_valid,
    input  logic [31:0]          fpu_result,
    input  logic                 fpu_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_result,
    output logic                 resp_err,
    output logic                 busy
);

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("fpu_req_arbiter: illegal NREQ/IDW/TIMEOUT_CYCLES combination");
    end

    arb_state_t      state, state_nxt;
    req_t            op_q;
    req_t            sel_req;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  last_grant;
    logic [31:0]     res_q;
    logic            err_q;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            tmo_hit;

    fpu_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_req.cmd  = req_cmd[32'(pick_idx) * 2 +: 2];
        sel_req.din1 = req_din1[32'(pick_idx) * 32 +: 32];
        sel_req.din2 = req_din2[32'(pick_idx) * 32 +: 32];
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;

    // Held at zero outside ISSUE so it is already cleared on ISSUE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == ISSUE) && !fpu_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = cmd_is_legal(sel_req.cmd) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (fpu_ready || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_q       <= sel_req;
                        id_q       <= pick_idx;
                        last_grant <= pick_idx;
                        res_q      <= '0;
                        err_q      <= !cmd_is_legal(sel_req.cmd);
                    end
                end
                ISSUE: begin
                    if (fpu_ready) begin
                        res_q <= fpu_result;
                        err_q <= 1'b0;
                    end else if (tmo_hit) begin
                        res_q <= '1;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gating keeps the grant pulse low while reset is held in IDLE.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset) begin
            req_ready = pick_grant;
        end
    end

    assign fpu_valid   = (state == ISSUE);
    assign fpu_cmd     = op_q.cmd;
    assign fpu_din1    = op_q.din1;
    assign fpu_din2    = op_q.din2;
    assign resp_valid  = (state == RESP);
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign resp_err    = err_q;
    assign busy        = (state != IDLE);

endmodule
